// File: rtl/mips_trace_checker.sv
// mips_trace_checker: self-checking trace monitor for the single-cycle MIPS core.
// Compares retired-instruction (pc, aluout) samples against a loadable table of
// expected pairs. It counts samples, matches and mismatches, tracks per-entry
// coverage and registers a pass/fail result when a run stops.
// Optional feature: define TRACE_CHECK_FIRST_ERR_EN to build the first-mismatch
// capture registers. When the macro is undefined, the first_err_* outputs are
// tied to 0.
module mips_trace_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_pc,
  input  logic [DATA_W-1:0] cfg_val,
  input  logic              start,
  input  logic              stop,
  input  logic              trace_valid,
  input  logic [DATA_W-1:0] trace_pc,
  input  logic [DATA_W-1:0] trace_val,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] first_err_pc,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   hit_q, hit_d;
  logic [DATA_W-1:0]  tbl_pc_q  [DEPTH];
  logic [DATA_W-1:0]  tbl_pc_d  [DEPTH];
  logic [DATA_W-1:0]  tbl_val_q [DEPTH];
  logic [DATA_W-1:0]  tbl_val_d [DEPTH];
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               pass_q, pass_d;

  logic               cfg_ok;
  logic               restart;
  logic               lk_hit;
  logic [DEPTH-1:0]   lk_sel;
  logic [DATA_W-1:0]  lk_exp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Writes beyond the populated depth are dropped rather than aliased.
  assign cfg_ok = ({1'b0, cfg_idx} < DEPTH_L);

  // Parallel PC search; scanning from the top down lets the lowest index win.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    lk_hit = 1'b0;
    lk_sel = '0;
    lk_exp = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (tbl_pc_q[i] == trace_pc)) begin
        lk_hit    = 1'b1;
        lk_sel    = '0;
        lk_sel[i] = 1'b1;
        lk_exp    = tbl_val_q[i];
      end
    end
  end

  // Next-state logic: table loads, sample accounting, run control, pass result.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    hit_d        = hit_q;
    tbl_pc_d     = tbl_pc_q;
    tbl_val_d    = tbl_val_q;
    sample_cnt_d = sample_cnt_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    restart      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we && cfg_ok) begin
          valid_d[cfg_idx]   = 1'b1;
          tbl_pc_d[cfg_idx]  = cfg_pc;
          tbl_val_d[cfg_idx] = cfg_val;
        end
        restart = start;
      end
      S_RUN: begin
        if (trace_valid) begin
          sample_cnt_d = sat_inc(sample_cnt_q);
          if (lk_hit) begin
            hit_d = hit_q | lk_sel;
            if (trace_val == lk_exp) match_cnt_d = sat_inc(match_cnt_q);
            else                     err_cnt_d   = sat_inc(err_cnt_q);
          end
        end
        // The sample taken on the stop cycle is folded into the result.
        if (stop) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0) && (&(hit_d | ~valid_q));
        end
      end
      S_DONE: begin
        restart = start;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      state_d      = S_RUN;
      hit_d        = '0;
      sample_cnt_d = '0;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
      pass_d       = 1'b0;
    end
  end

  // Control state, valid bits, coverage flags and counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      hit_q        <= '0;
      sample_cnt_q <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      hit_q        <= hit_d;
      sample_cnt_q <= sample_cnt_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
    end
  end

  // Table payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately not reset; the valid bits alone decide
    // whether an entry takes part in a lookup.
    tbl_pc_q  <= tbl_pc_d;
    tbl_val_q <= tbl_val_d;
  end

`ifdef TRACE_CHECK_FIRST_ERR_EN
  logic              mismatch;
  logic              fe_seen_q, fe_seen_d;
  logic [DATA_W-1:0] fe_pc_q, fe_pc_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0] fe_act_q, fe_act_d;

  assign mismatch = (state_q == S_RUN) && trace_valid && lk_hit && (trace_val != lk_exp);

  // Capture the first mismatch of a run, then freeze until the next start.
  always_comb begin
    fe_seen_d = fe_seen_q;
    fe_pc_d   = fe_pc_q;
    fe_exp_d  = fe_exp_q;
    fe_act_d  = fe_act_q;
    if (restart) begin
      fe_seen_d = 1'b0;
      fe_pc_d   = '0;
      fe_exp_d  = '0;
      fe_act_d  = '0;
    end else if (mismatch && !fe_seen_q) begin
      fe_seen_d = 1'b1;
      fe_pc_d   = trace_pc;
      fe_exp_d  = lk_exp;
      fe_act_d  = trace_val;
    end
  end

  // First-error capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fe_seen_q <= 1'b0;
      fe_pc_q   <= '0;
      fe_exp_q  <= '0;
      fe_act_q  <= '0;
    end else begin
      fe_seen_q <= fe_seen_d;
      fe_pc_q   <= fe_pc_d;
      fe_exp_q  <= fe_exp_d;
      fe_act_q  <= fe_act_d;
    end
  end

  assign first_err_pc  = fe_pc_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_act = fe_act_q;
`else
  assign first_err_pc  = '0;
  assign first_err_exp = '0;
  assign first_err_act = '0;
`endif

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign sample_cnt = sample_cnt_q;
  assign match_cnt  = match_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/mips_trace_checker.md
# mips_trace_checker

Parametrised self-checking trace monitor for the single-cycle MIPS core. It holds a loadable table of expected (PC, ALU result) pairs and compares every retired-instruction sample against it. It counts matches, mismatches and coverage, and reports pass/fail as a registered result. It sits beside `singleMIPS` in simulation and FPGA bring-up, replacing hand-written per-PC checks with a reusable, depth- and width-configurable block.

## Interface
- `DATA_W`, 32: width of PC and ALU-result fields.
- `DEPTH`, 16: number of expected-value table entries.
- `IDX_W`, 4: table index width; must satisfy 2^IDX_W >= DEPTH.
- `CNT_W`, 16: width of the sample, match and error counters.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears the table valid bits, counters, flags and FSM.
- `cfg_we`  in  1  table write strobe; honoured only in IDLE.
- `cfg_idx`  in  IDX_W  entry index; writes with `cfg_idx >= DEPTH` are ignored.
- `cfg_pc`  in  DATA_W  expected PC of the entry.
- `cfg_val`  in  DATA_W  expected ALU result of the entry.
- `start`  in  1  pulse: IDLE/DONE -> RUN.
- `stop`  in  1  pulse: RUN -> DONE.
- `trace_valid`  in  1  sample strobe, one per retired instruction.
- `trace_pc`  in  DATA_W  core `pc`.
- `trace_val`  in  DATA_W  core `aluout`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`; high when the error count is zero and every valid entry has been hit at least once.
- `sample_cnt`  out  CNT_W  number of samples taken in RUN.
- `match_cnt`  out  CNT_W  samples whose PC hit an entry and whose value matched.
- `err_cnt`  out  CNT_W  samples whose PC hit an entry and whose value mismatched.
- `first_err_pc`  out  DATA_W  PC of the first mismatch (see Configuration).
- `first_err_exp`  out  DATA_W  expected value at the first mismatch.
- `first_err_act`  out  DATA_W  actual value at the first mismatch.

## Operation
- FSM states are IDLE, RUN and DONE; reset enters IDLE.
- IDLE:
  - `cfg_we` writes `{valid=1, pc, val}` into entry `cfg_idx`.
  - `start` clears all counters, all per-entry hit flags and the first-error registers, then moves to RUN. The table contents are kept.
- RUN:
  - Each `trace_valid` increments `sample_cnt`.
  - `trace_pc` is searched in parallel against all valid entries. When several entries carry the same PC, the lowest index wins.
  - On a hit, the entry's hit flag is set. If the values are equal, `match_cnt` increments; otherwise `err_cnt` increments.
  - A PC that hits no entry is counted in `sample_cnt` only.
  - `cfg_we` is ignored.
  - `stop` moves the FSM to DONE. A `trace_valid` in the same cycle as `stop` is still checked and counted.
- DONE:
  - All outputs are held.
  - `pass` is `(err_cnt==0) && (hit flag set for every valid entry)`. An empty table with no errors gives pass=1.
  - `start` returns to RUN, clearing state as above.
  - Moving back to IDLE for reloading requires `reset`.
- `start` in RUN and `stop` in IDLE/DONE are ignored.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Comparison is exact over all DATA_W bits; there is no masking.

## Timing
- Reset values:
  - `busy`, `done`, `pass` = 0.
  - All counters = 0.
  - `first_err_*` = 0.
  - All table entries invalid.
- Table writes take effect on the next cycle; a sample may hit an entry written one cycle earlier.
- Sample-to-counter latency is 1 cycle: the counter updates on the edge that samples `trace_valid`.
- `done` and `pass` become valid 1 cycle after the `stop` edge. `pass` is registered and stable throughout DONE.
- A reset asserted mid-RUN takes priority over every other input in that cycle. The block returns to IDLE with an empty table on the next edge.
- The block accepts one sample per cycle with no back-pressure.

## Configuration
- Macro `TRACE_CHECK_FIRST_ERR_EN`.
- Defined: the first mismatch after each `start` latches `trace_pc`, the expected value and `trace_val` into `first_err_pc`, `first_err_exp` and `first_err_act`. These registers are frozen until the next `start` or `reset`.
- Undefined: no capture registers are built, and the three `first_err_*` outputs are tied to 0.
- Counting and pass/fail behaviour are identical in both builds.

## Test plan
- Load entries {0x00->0, 0x04->2, 0x08->4, 0x0C->1}, `start`, feed exactly those four samples, `stop` -> `match_cnt`=4, `err_cnt`=0, `sample_cnt`=4, `pass`=1.
- Same table, feed 0x08 with `aluout`=5 -> `err_cnt`=1 and `pass`=0. With the macro defined, `first_err_pc`=0x08, `first_err_exp`=4, `first_err_act`=5.
- Same table, feed only 0x00, 0x04 and 0x20, `stop` -> `sample_cnt`=3, `match_cnt`=2, `err_cnt`=0, `pass`=0 because of missing coverage.
- Load duplicate entries idx1 {0x10->3} and idx5 {0x10->7}, feed 0x10 with value 3 -> `match_cnt`=1, `err_cnt`=0 (lowest index wins).
- Assert `reset` mid-RUN after 2 samples -> next cycle `busy`=0, all counters 0. A `start` with no reload, followed by `stop`, gives `pass`=1 on the empty table.
- Run with CNT_W=2 and 5 matching samples -> `match_cnt`=3 (saturated), `sample_cnt`=3.
